xbar_slave_port_ctrl: RTL and testbench
=======================================

// Module: xbar_slave_port_ctrl
// PURPOSE
//   Per-slave transaction sequencer for the 2-master x 2-slave request crossbar. Picks one of two
//   masters whose address targets this slave (addr[31] == SLAVE_ID) by round-robin, drives the
//   request to the slave, and holds the grant through the slave ack and response. Returns the
//   response to the granted master. One instance per slave port.
// PARAMETERS
//   SLAVE_ID     1'b0  slave index; matched against m*_addr[31]
//   DATA_W       32    wdata/rdata width
//   TIMEOUT_CYC  16    watchdog limit in cycles, used only with XBAR_TIMEOUT_EN (>=2)
// PORTS
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high
//   m0_req/m1_req     in  1   master request, held high until its m*_ack
//   m0_cmd/m1_cmd     in  1   1 = write, 0 = read
//   m0_addr/m1_addr   in  32  address; bit 31 selects the slave
//   m0_wdata/m1_wdata in  DATA_W  write data
//   m0_ack/m1_ack     out 1   one-cycle pulse: request accepted by the slave
//   m0_resp/m1_resp   out 1   one-cycle pulse: response valid
//   m_rdata      out  DATA_W  response data, valid with m*_resp (shared by both masters)
//   m_err        out  1       error flag, valid with m*_resp
//   s_req        out  1       request to the slave
//   s_cmd/s_addr/s_wdata out 1/32/DATA_W  latched fields of the granted master
//   s_ack        in   1       slave accepts the request
//   s_resp       in   1       slave response valid
//   s_rdata      in   DATA_W  slave response data
// BEHAVIOUR
//   - All outputs are registered. Reset values: every output 0, state IDLE, last_grant = 1 (so
//     master 0 wins the first tie). Asserting reset mid-transaction aborts it immediately. No
//     ack or resp is issued for the aborted transaction.
//   - eligible[i] = mi_req & (mi_addr[31] == SLAVE_ID).
//   - FSM IDLE -> REQ -> WAIT_RESP -> IDLE.
//   - IDLE:
//       - No eligible master: stay in IDLE.
//       - One eligible master: grant it.
//       - Both eligible: grant ~last_grant.
//       - On a grant: latch cmd, addr and wdata into s_*, set s_req = 1 the next cycle (1-cycle
//         latency), and go to REQ.
//   - REQ: s_req stays high and s_* stay stable until s_ack is sampled high. Then s_req = 0,
//     m{g}_ack pulses for one cycle, and the FSM goes to WAIT_RESP.
//   - WAIT_RESP: reads and writes both wait for s_resp. When s_resp is sampled high: m_rdata
//     takes s_rdata (writes pass s_rdata through unchanged), m_err = 0, m{g}_resp pulses for one
//     cycle, last_grant = g, and the FSM returns to IDLE.
//   - s_ack and s_resp may be high in the same cycle in REQ. That counts as an ack only; the
//     response is taken on a later s_resp.
//   - New requests are sampled only in IDLE. The earliest next grant comes the cycle after resp.
//   - A master that drops req before its ack does not cancel a grant already issued.
//   - s_ack or s_resp sampled outside the state that expects it is ignored.
// CONFIGURATION
//   XBAR_TIMEOUT_EN defined:
//     - An 8-bit counter clears on entry to REQ and to WAIT_RESP, and increments every cycle in
//       those states.
//     - When the counter reaches TIMEOUT_CYC-1 with no s_ack or s_resp: s_req = 0,
//       m{g}_resp pulses with m_err = 1 and m_rdata = ERR_RDATA, last_grant = g, go to IDLE.
//     - If a timeout occurs in REQ, m{g}_ack is never pulsed.
//   XBAR_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely. The m_err port remains
//   and is held at 0.
// STRUCTURE
//   - Package xbar_pkg holds:
//       - state enum {IDLE, REQ, WAIT_RESP};
//       - CMD_RD = 1'b0, CMD_WR = 1'b1;
//       - ADDR_SEL_BIT = 31;
//       - ERR_RDATA = 32'hDEAD_BEEF.
//   - Sub-module rr_pick2: combinational 2-way round-robin pick. Inputs eligible[1:0] and
//     last_grant; outputs gnt_valid and gnt_idx.
// TESTING
//   1. Reset with both masters requesting slave SLAVE_ID -> all outputs 0 while reset is high.
//      After release, master 0 is granted, s_addr = m0_addr, and s_req rises 1 cycle later.
//   2. Both masters request continuously; slave gives s_ack the cycle after s_req and s_resp
//      2 cycles later -> grants alternate 0,1,0,1, each with exactly one ack and one resp pulse.
//   3. m0_addr[31] != SLAVE_ID and m1 targets this slave -> only m1 is granted; m0 never sees
//      an ack from this instance.
//   4. Read from m1 with s_rdata = 32'h000FEED1 -> m1_resp pulses with m_rdata = 32'h000FEED1
//      and m_err = 0; m0_resp stays 0.
//   5. Reset asserted in WAIT_RESP -> s_req and all pulses are 0 asynchronously. After release
//      the FSM is in IDLE and master 0 wins the next tie.
//   6. (XBAR_TIMEOUT_EN, TIMEOUT_CYC = 16) s_ack never arrives -> m0_resp pulses with
//      m_err = 1 and m_rdata = 32'hDEAD_BEEF, 16 cycles after s_req rose; m0_ack never pulses.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared types and constants for the 2x2 request crossbar slave ports.
//   state_e     sequencer states IDLE -> REQ -> WAIT_RESP
//   CMD_RD/WR   command encoding on m*_cmd / s_cmd
//   ADDR_SEL_BIT address bit that selects the slave
//   ERR_RDATA   read data returned with m_err on a watchdog timeout
package xbar_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;
    localparam int ADDR_SEL_BIT = 31;
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick.
//   eligible_i[1:0]  per-master eligibility
//   last_grant_i     index granted last; the other master wins a tie
//   gnt_valid_o      at least one master eligible
//   gnt_idx_o        index of the picked master
module rr_pick2 (
    input  logic [1:0] eligible_i,
    input  logic       last_grant_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);
    assign gnt_valid_o = |eligible_i;
    assign gnt_idx_o   = &eligible_i ? ~last_grant_i : eligible_i[1];
endmodule

// File: rtl/xbar_slave_port_ctrl.sv
// xbar_slave_port_ctrl: per-slave sequencer arbitrating two masters onto one slave.
//   clk, reset                 rising-edge clock, async active-high reset
//   m{0,1}_req/cmd/addr/wdata  master requests; addr[31] selects the slave
//   m{0,1}_ack, m{0,1}_resp    one-cycle pulses back to the granted master
//   m_rdata, m_err             response data/error, valid with m*_resp
//   s_req/cmd/addr/wdata       request to the slave, held until s_ack
//   s_ack, s_resp, s_rdata     slave handshake and response data
// Optional watchdog: define XBAR_TIMEOUT_EN to abort a transaction after TIMEOUT_CYC cycles
// without s_ack/s_resp (m_err = 1, m_rdata = ERR_RDATA). Otherwise m_err is held at 0.
module xbar_slave_port_ctrl
    import xbar_pkg::*;
#(
    parameter logic SLAVE_ID    = 1'b0,
    parameter int   DATA_W      = 32,
    parameter int   TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_cmd,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_cmd,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_resp,
    output logic              m1_resp,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_err,
    output logic              s_req,
    output logic              s_cmd,
    output logic [31:0]       s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic              s_resp,
    input  logic [DATA_W-1:0] s_rdata
);
    state_e            state_q, state_d;
    logic              last_q, last_d, gnt_q, gnt_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;
    logic              m_err_q, m_err_d;
    logic              s_req_q, s_req_d, s_cmd_q, s_cmd_d;
    logic [31:0]       s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [1:0]        eligible;
    logic              gnt_valid, gnt_idx, to_fire;

    // TIMEOUT_CYC needs at least one waiting cycle and must fit the 8-bit watchdog counter
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout_cyc
    end

    assign eligible = {m1_req & (m1_addr[ADDR_SEL_BIT] == SLAVE_ID),
                       m0_req & (m0_addr[ADDR_SEL_BIT] == SLAVE_ID)};

    rr_pick2 u_pick (
        .eligible_i  (eligible),
        .last_grant_i(last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

`ifdef XBAR_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    // restarts on every state change so REQ and WAIT_RESP each get a full budget
    assign cnt_d   = (state_d != state_q || state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
    assign to_fire = (state_q != IDLE) && (cnt_q == 8'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_resp_d = 1'b0;
        m1_resp_d = 1'b0;
        m_rdata_d = m_rdata_q;
        m_err_d   = m_err_q;
        s_req_d   = s_req_q;
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        case (state_q)
            IDLE: if (gnt_valid) begin
                state_d   = REQ;
                gnt_d     = gnt_idx;
                s_req_d   = 1'b1;
                s_cmd_d   = gnt_idx ? m1_cmd : m0_cmd;
                s_addr_d  = gnt_idx ? m1_addr : m0_addr;
                s_wdata_d = gnt_idx ? m1_wdata : m0_wdata;
            end
            // a simultaneous s_resp is deliberately dropped here: it is an ack only
            REQ: if (s_ack) begin
                state_d  = WAIT_RESP;
                s_req_d  = 1'b0;
                m0_ack_d = ~gnt_q;
                m1_ack_d = gnt_q;
            end else if (to_fire) begin
                state_d   = IDLE;
                s_req_d   = 1'b0;
                m0_resp_d = ~gnt_q;
                m1_resp_d = gnt_q;
                m_err_d   = 1'b1;
                m_rdata_d = DATA_W'(ERR_RDATA);
                last_d    = gnt_q;
            end
            WAIT_RESP: if (s_resp || to_fire) begin
                state_d   = IDLE;
                m0_resp_d = ~gnt_q;
                m1_resp_d = gnt_q;
                m_err_d   = ~s_resp;
                m_rdata_d = s_resp ? s_rdata : DATA_W'(ERR_RDATA);
                last_d    = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_resp_q <= 1'b0;
            m1_resp_q <= 1'b0;
            m_rdata_q <= '0;
            m_err_q   <= 1'b0;
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_resp_q <= m0_resp_d;
            m1_resp_q <= m1_resp_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign m0_ack  = m0_ack_q;
    assign m1_ack  = m1_ack_q;
    assign m0_resp = m0_resp_q;
    assign m1_resp = m1_resp_q;
    assign m_rdata = m_rdata_q;
    assign m_err   = m_err_q;
    assign s_req   = s_req_q;
    assign s_cmd   = s_cmd_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
endmodule

// File: tb/tb_xbar_slave_port_ctrl.sv
// tb_xbar_slave_port_ctrl: scoreboard bench for xbar_slave_port_ctrl (SLAVE_ID = 0).
module tb_xbar_slave_port_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_cmd = 1'b0, m1_req = 1'b0, m1_cmd = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_resp, m1_resp, m_err, s_req, s_cmd;
    logic [31:0] m_rdata, s_addr, s_wdata;
    logic        s_ack = 1'b0, s_resp = 1'b0;
    logic [31:0] s_rdata = '0;

    typedef struct {
        int          m;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, failures = 0;
    int n_ack0 = 0, n_ack1 = 0, n_resp0 = 0, n_resp1 = 0;
    int e_ack0 = 0, e_ack1 = 0, e_resp0 = 0, e_resp1 = 0;

    always #5 clk = ~clk;

    xbar_slave_port_ctrl dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_resp(m0_resp), .m1_resp(m1_resp),
        .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    always @(negedge clk) begin
        n_ack0  <= n_ack0 + int'(m0_ack);
        n_ack1  <= n_ack1 + int'(m1_ack);
        n_resp0 <= n_resp0 + int'(m0_resp);
        n_resp1 <= n_resp1 + int'(m1_resp);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int m, input logic [31:0] rdata);
        exp_t e;
        e.m     = m;
        e.cmd   = m ? m1_cmd : m0_cmd;
        e.addr  = m ? m1_addr : m0_addr;
        e.wdata = m ? m1_wdata : m0_wdata;
        e.rdata = rdata;
        exp_q.push_back(e);
        if (m == 0) begin e_ack0++; e_resp0++; end
        else begin e_ack1++; e_resp1++; end
    endtask

    // acts as the slave for one expected transaction; returns on the negedge where resp is visible
    task automatic run_txn(input bit same_cycle, input bit abort);
        exp_t e;
        int lat = 0;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        do begin @(posedge clk); @(negedge clk); lat++; end while (!s_req && lat < 20);
        check("req_lat", 32'(lat), 32'd1);
        check("s_addr", s_addr, e.addr);
        check("s_cmd", 32'(s_cmd), 32'(e.cmd));
        check("s_wdata", s_wdata, e.wdata);
        @(posedge clk); @(negedge clk);
        check("s_req_hold", 32'(s_req), 32'd1);
        check("s_addr_hold", s_addr, e.addr);
        s_ack = 1'b1;
        if (same_cycle) begin s_resp = 1'b1; s_rdata = 32'hBAD0_0BAD; end
        @(posedge clk); @(negedge clk);
        s_ack = 1'b0; s_resp = 1'b0;
        check("ack0", 32'(m0_ack), 32'(e.m == 0));
        check("ack1", 32'(m1_ack), 32'(e.m == 1));
        check("s_req_drop", 32'(s_req), 32'd0);
        check("no_early_resp", 32'(m0_resp | m1_resp), 32'd0);
        @(posedge clk); @(negedge clk);
        check("ack_pulse_end", 32'(m0_ack | m1_ack), 32'd0);
        if (abort) begin
            #2 reset = 1'b1;
            #1;
            check("abort_s_req", 32'(s_req), 32'd0);
            check("abort_pulses", {m0_ack, m1_ack, m0_resp, m1_resp}, 32'd0);
            check("abort_rdata", m_rdata, 32'd0);
            check("abort_s_addr", s_addr, 32'd0);
            if (e.m == 0) e_resp0--; else e_resp1--;
            s_resp = 1'b1;
            @(negedge clk);
            s_resp = 1'b0;
            reset = 1'b0;
            return;
        end
        s_resp = 1'b1; s_rdata = e.rdata;
        @(posedge clk); @(negedge clk);
        s_resp = 1'b0;
        check("resp0", 32'(m0_resp), 32'(e.m == 0));
        check("resp1", 32'(m1_resp), 32'(e.m == 1));
        check("m_rdata", m_rdata, e.rdata);
        check("m_err", 32'(m_err), 32'd0);
    endtask

    initial begin
        int c;
        m0_req = 1'b1; m0_cmd = 1'b1; m0_addr = 32'h0000_1000; m0_wdata = 32'hA0A0_0001;
        m1_req = 1'b1; m1_cmd = 1'b0; m1_addr = 32'h0000_2000; m1_wdata = 32'hB0B0_0002;
        repeat (3) @(negedge clk);
        check("rst_s_req", 32'(s_req), 32'd0);
        check("rst_pulses", {m0_ack, m1_ack, m0_resp, m1_resp, m_err}, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        push(0, 32'h1111_0000);
        reset = 1'b0;
        run_txn(0, 0);
        push(1, 32'h2222_0001); push(0, 32'h3333_0002); push(1, 32'h4444_0003); push(0, 32'h5555_0004);
        run_txn(0, 0); run_txn(1, 0); run_txn(0, 0); run_txn(0, 0);
        m0_addr = 32'h8000_1000;
        push(1, 32'h6666_0005); push(1, 32'h7777_0006);
        run_txn(0, 0); run_txn(0, 0);
        m0_req = 1'b0;
        push(1, 32'h000F_EED1);
        run_txn(0, 0);
        m1_req = 1'b0;
        s_ack = 1'b1; s_resp = 1'b1;
        repeat (2) @(negedge clk);
        s_ack = 1'b0; s_resp = 1'b0;
        @(negedge clk);
        check("idle_s_req", 32'(s_req), 32'd0);
        check("idle_no_pulse", 32'(n_ack0 + n_ack1 + n_resp0 + n_resp1), 32'(e_ack0 + e_ack1 + e_resp0 + e_resp1));
        m0_addr = 32'h0000_1004; m0_req = 1'b1;
        push(0, 32'h8888_0007);
        run_txn(0, 0);
        m1_req = 1'b1;
        push(1, 32'h9999_0008);
        run_txn(0, 1);
        push(0, 32'hAAAA_0009);
        run_txn(0, 0);
`ifdef XBAR_TIMEOUT_EN
        m1_req = 1'b0;
        c = 0;
        do begin @(posedge clk); @(negedge clk); c++; end while (!s_req && c < 20);
        m0_req = 1'b0;
        check("to_req", 32'(s_req), 32'd1);
        c = 0;
        while (!m0_resp && c < 40) begin @(posedge clk); @(negedge clk); c++; end
        check("to_lat", 32'(c), 32'd16);
        check("to_err", 32'(m_err), 32'd1);
        check("to_rdata", m_rdata, 32'hDEAD_BEEF);
        check("to_s_req", 32'(s_req), 32'd0);
        e_resp0++;
`else
        c = 0;
        m0_req = 1'b0; m1_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("n_ack0", 32'(n_ack0), 32'(e_ack0));
        check("n_ack1", 32'(n_ack1), 32'(e_ack1));
        check("n_resp0", 32'(n_resp0), 32'(e_resp0));
        check("n_resp1", 32'(n_resp1), 32'(e_resp1));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end
endmodule
